// File: rtl/wcf_pkg.sv
// Shared constants and helpers for the width-converting FIFO.
package wcf_pkg;

  localparam int unsigned WCF_IN_W  = 16;
  localparam int unsigned WCF_OUT_W = 8;
  localparam int unsigned WCF_DEPTH = 16;

  // Ceiling log2 that never returns less than 1, so single-entry indices still get a bit.
  function automatic int unsigned wcf_clog2(input int unsigned value);
    int unsigned res;
    res = 32'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 32'd1;
    end
    return (res == 32'd0) ? 32'd1 : res;
  endfunction

endpackage

// File: rtl/width_conv_fifo_if.sv
// Producer/consumer bundle for width_conv_fifo; the level port exists only with WCFIFO_LEVEL_EN.
interface width_conv_fifo_if
  import wcf_pkg::*;
#(
  parameter int unsigned IN_W  = WCF_IN_W,
  parameter int unsigned OUT_W = WCF_OUT_W,
  parameter int unsigned DEPTH = WCF_DEPTH
);

  logic             input_valid;
  logic             input_enable;
  logic [IN_W-1:0]  data_in;
  logic             output_valid;
  logic             output_enable;
  logic [OUT_W-1:0] data_out;

`ifdef WCFIFO_LEVEL_EN
  localparam int unsigned R   = IN_W / OUT_W;
  localparam int unsigned AW  = wcf_clog2(DEPTH);
  localparam int unsigned LVW = AW + R + 1;

  logic [LVW-1:0] level;

  modport master (
    output input_valid, data_in, output_enable,
    input  input_enable, output_valid, data_out, level
  );

  modport slave (
    input  input_valid, data_in, output_enable,
    output input_enable, output_valid, data_out, level
  );
`else
  modport master (
    output input_valid, data_in, output_enable,
    input  input_enable, output_valid, data_out
  );

  modport slave (
    input  input_valid, data_in, output_enable,
    output input_enable, output_valid, data_out
  );
`endif

endinterface

// File: rtl/wcf_lane_mux.sv
// Selects one OUT_W lane of a stored word, honouring the configured lane order.
module wcf_lane_mux
  import wcf_pkg::*;
#(
  parameter int unsigned IN_W      = WCF_IN_W,
  parameter int unsigned OUT_W     = WCF_OUT_W,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic [IN_W-1:0]                           word_i,
  input  logic [wcf_clog2(IN_W / OUT_W)-1:0]        ln_i,
  output logic [OUT_W-1:0]                          lane_o
);

  localparam int unsigned R  = IN_W / OUT_W;
  localparam int unsigned LW = wcf_clog2(R);

  logic [LW-1:0] sel_c;

  assign sel_c = MSB_FIRST ? (LW'(R - 1) - ln_i) : ln_i;

  always_comb begin
    lane_o = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (LW'(i) == sel_c) lane_o = word_i[i*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/width_conv_fifo.sv
// Width-converting first-word-fall-through FIFO: IN_W words in, OUT_W lanes out.
// Define WCFIFO_LEVEL_EN to add the lane-occupancy port (bus.level).
module width_conv_fifo
  import wcf_pkg::*;
#(
  parameter int unsigned IN_W      = WCF_IN_W,
  parameter int unsigned OUT_W     = WCF_OUT_W,
  parameter int unsigned DEPTH     = WCF_DEPTH,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  width_conv_fifo_if.slave   bus
);

  localparam int unsigned R  = IN_W / OUT_W;
  localparam int unsigned AW = wcf_clog2(DEPTH);
  localparam int unsigned LW = wcf_clog2(R);
  localparam int unsigned CW = AW + 1;

  if ((OUT_W == 0) || ((IN_W % OUT_W) != 0)) begin : g_bad_ratio
    $fatal(1, "width_conv_fifo: IN_W must be a non-zero multiple of OUT_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "width_conv_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [LW-1:0]    ln_q, ln_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             full_n_c;
  logic             nempty_c;
  logic             wr_fire_c;
  logic             rd_fire_c;
  logic             pop_c;
  logic [OUT_W-1:0] lane_c;

  // Flags come from registered count only, so there is no input-to-flag path.
  assign full_n_c  = (cnt_q != CW'(DEPTH));
  assign nempty_c  = (cnt_q != '0);
  assign wr_fire_c = bus.input_valid && full_n_c;
  assign rd_fire_c = nempty_c && bus.output_enable;
  assign pop_c     = rd_fire_c && (ln_q == LW'(R - 1));

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    ln_d  = ln_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      ln_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_fire_c) wp_d = wp_q + AW'(1);
      if (pop_c) begin
        rp_d = rp_q + AW'(1);
        ln_d = '0;
      end else if (rd_fire_c) begin
        ln_d = ln_q + LW'(1);
      end
      case ({wr_fire_c, pop_c})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ln_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ln_q  <= ln_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; a flush leaves old words in place.
  always_ff @(posedge clk) begin
    if (wr_fire_c && !flush) mem_q[wp_q] <= bus.data_in;
  end

  wcf_lane_mux #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_mux (
    .word_i (mem_q[rp_q]),
    .ln_i   (ln_q),
    .lane_o (lane_c)
  );

  assign bus.input_enable = full_n_c;
  assign bus.output_valid = nempty_c;
  assign bus.data_out     = nempty_c ? lane_c : '0;

`ifdef WCFIFO_LEVEL_EN
  localparam int unsigned LVW = AW + R + 1;

  assign bus.level = (LVW'(cnt_q) * LVW'(R)) - LVW'(ln_q);
`endif

endmodule

// File: tb/tb_width_conv_fifo.sv
// Self-checking bench for width_conv_fifo: directed scenarios plus random traffic against a lane-queue model.
module tb_width_conv_fifo;
  import wcf_pkg::*;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned R  = IW / OW;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  int nchecks = 0;
  int nerr    = 0;

  // Reference: the FIFO seen as a plain queue of lanes in emission order.
  logic [OW-1:0] mq[$];

  width_conv_fifo_if #(.IN_W(IW), .OUT_W(OW), .DEPTH(DP)) a_if ();
  width_conv_fifo_if #(.IN_W(32), .OUT_W(8),  .DEPTH(4))  b_if ();

  width_conv_fifo #(.IN_W(IW), .OUT_W(OW), .DEPTH(DP), .MSB_FIRST(1'b0)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_a),
    .bus   (a_if.slave)
  );

  width_conv_fifo #(.IN_W(32), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_b),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ie();
    return ((mq.size() + R - 1) / R) < DP;
  endfunction

  task automatic check_a(input string tag);
    chk({tag, ".ov"},   64'(a_if.output_valid), 64'(mq.size() != 0));
    chk({tag, ".ie"},   64'(a_if.input_enable), 64'(m_ie()));
    chk({tag, ".dout"}, 64'(a_if.data_out), (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
`ifdef WCFIFO_LEVEL_EN
    chk({tag, ".lvl"},  64'(a_if.level), 64'(mq.size()));
`endif
  endtask

  // One clock of DUT A with the model advanced from the pre-edge state.
  task automatic step_a(input bit iv, input logic [IW-1:0] din, input bit oe, input bit fl,
                        input string tag);
    bit wr, rd;
    a_if.input_valid   = iv;
    a_if.data_in       = din;
    a_if.output_enable = oe;
    flush_a            = fl;
    wr = iv && m_ie();
    rd = oe && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (rd) void'(mq.pop_front());
      if (wr) for (int i = 0; i < R; i++) mq.push_back(din[i*OW +: OW]);
    end
    check_a(tag);
  endtask

  task automatic drain_a(input string tag);
    int guard;
    guard = 0;
    while (mq.size() != 0 && guard < 200) begin
      step_a(1'b0, '0, 1'b1, 1'b0, tag);
      guard++;
    end
    chk({tag, ".empty"}, 64'(a_if.output_valid), 64'd0);
  endtask

  initial begin
    a_if.input_valid   = 1'b0;
    a_if.data_in       = '0;
    a_if.output_enable = 1'b0;
    b_if.input_valid   = 1'b0;
    b_if.data_in       = '0;
    b_if.output_enable = 1'b0;

    #1;
    check_a("rst_hold");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic LSB-first ordering
    step_a(1'b1, 16'hA1B2, 1'b0, 1'b0, "basic.wr0");
    chk("basic.l0", 64'(a_if.data_out), 64'hB2);
    step_a(1'b1, 16'hC3D4, 1'b0, 1'b0, "basic.wr1");
    step_a(1'b0, '0, 1'b1, 1'b0, "basic.rd0");
    chk("basic.l1", 64'(a_if.data_out), 64'hA1);
    step_a(1'b0, '0, 1'b1, 1'b0, "basic.rd1");
    chk("basic.l2", 64'(a_if.data_out), 64'hD4);
    step_a(1'b0, '0, 1'b1, 1'b0, "basic.rd2");
    chk("basic.l3", 64'(a_if.data_out), 64'hC3);
    step_a(1'b0, '0, 1'b1, 1'b0, "basic.rd3");
    chk("basic.ov_end", 64'(a_if.output_valid), 64'd0);
    chk("basic.dout_end", 64'(a_if.data_out), 64'd0);

`ifdef WCFIFO_LEVEL_EN
    step_a(1'b0, '0, 1'b0, 1'b1, "lvl.fl");
    chk("lvl.zero", 64'(a_if.level), 64'd0);
    for (int i = 0; i < 3; i++) step_a(1'b1, 16'h4400 + 16'(i), 1'b0, 1'b0, "lvl.wr");
    chk("lvl.six", 64'(a_if.level), 64'd6);
    step_a(1'b0, '0, 1'b1, 1'b0, "lvl.rd");
    chk("lvl.five", 64'(a_if.level), 64'd5);
`endif

    // Full, refused 17th write, drain across the wrap with interleaved writes
    step_a(1'b0, '0, 1'b0, 1'b1, "full.fl");
    for (int i = 0; i < 16; i++) step_a(1'b1, 16'(i), 1'b0, 1'b0, "full.fill");
    chk("full.ie0", 64'(a_if.input_enable), 64'd0);
`ifdef WCFIFO_LEVEL_EN
    chk("full.lvl32", 64'(a_if.level), 64'd32);
`endif
    step_a(1'b1, 16'hDEAD, 1'b0, 1'b0, "full.wr17");
    chk("full.ie0b", 64'(a_if.input_enable), 64'd0);
    chk("full.head", 64'(a_if.data_out), 64'h00);
    for (int i = 0; i < 10; i++) step_a(1'b0, '0, 1'b1, 1'b0, "full.rd");
    for (int k = 0; k < 8; k++) step_a(1'b1, 16'h0100 + 16'(k), 1'b1, 1'b0, "full.mix");
    drain_a("full.drain");

    // Write plus final-lane read with cnt=3, ln=1
    step_a(1'b0, '0, 1'b0, 1'b1, "sim.fl");
    step_a(1'b1, 16'h1A0A, 1'b0, 1'b0, "sim.wr");
    step_a(1'b1, 16'h1B0B, 1'b0, 1'b0, "sim.wr");
    step_a(1'b1, 16'h1C0C, 1'b0, 1'b0, "sim.wr");
    step_a(1'b0, '0, 1'b1, 1'b0, "sim.rd");
    chk("sim.ln1", 64'(a_if.data_out), 64'h1A);
    step_a(1'b1, 16'h1D0D, 1'b1, 1'b0, "sim.both");
    chk("sim.next", 64'(a_if.data_out), 64'h0B);
`ifdef WCFIFO_LEVEL_EN
    chk("sim.lvl", 64'(a_if.level), 64'd6);
`endif
    drain_a("sim.drain");

    // Full with ln=1: write refused while the pop frees a slot
    step_a(1'b0, '0, 1'b0, 1'b1, "fr.fl");
    for (int i = 0; i < 16; i++) step_a(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, "fr.fill");
    step_a(1'b0, '0, 1'b1, 1'b0, "fr.rd");
    chk("fr.ie0", 64'(a_if.input_enable), 64'd0);
    step_a(1'b1, 16'hBAD0, 1'b1, 1'b0, "fr.both");
    chk("fr.ie1", 64'(a_if.input_enable), 64'd1);
    chk("fr.next", 64'(a_if.data_out), 64'h01);
    drain_a("fr.drain");

    // Flush mid-word drops a concurrent write
    step_a(1'b0, '0, 1'b0, 1'b1, "fm.fl0");
    for (int i = 0; i < 5; i++) step_a(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, "fm.wr");
    step_a(1'b0, '0, 1'b1, 1'b0, "fm.rd");
    step_a(1'b1, 16'hBEEF, 1'b0, 1'b1, "fm.flush");
    chk("fm.ov0", 64'(a_if.output_valid), 64'd0);
    step_a(1'b0, '0, 1'b0, 1'b0, "fm.idle");
    chk("fm.ov0b", 64'(a_if.output_valid), 64'd0);
    step_a(1'b1, 16'h5A6B, 1'b0, 1'b0, "fm.wr2");
    chk("fm.lane0", 64'(a_if.data_out), 64'h6B);
    drain_a("fm.drain");

    // Asynchronous reset mid-word clears outputs without a clock edge
    for (int i = 0; i < 5; i++) step_a(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0, "rm.wr");
    step_a(1'b0, '0, 1'b1, 1'b0, "rm.rd");
    a_if.input_valid   = 1'b1;
    a_if.data_in       = 16'hCAFE;
    a_if.output_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check_a("rm.async");
    chk("rm.ie1", 64'(a_if.input_enable), 64'd1);
    chk("rm.ov0", 64'(a_if.output_valid), 64'd0);
    chk("rm.dout0", 64'(a_if.data_out), 64'd0);
    a_if.input_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step_a(1'b1, 16'h7788, 1'b0, 1'b0, "rm.wr2");
    chk("rm.lane0", 64'(a_if.data_out), 64'h88);
    step_a(1'b0, '0, 1'b1, 1'b0, "rm.rd2");
    chk("rm.lane1", 64'(a_if.data_out), 64'h77);
    drain_a("rm.drain");

    // MSB-first 32->8 instance
    b_if.input_valid = 1'b1;
    b_if.data_in     = 32'h11223344;
    @(posedge clk);
    #1;
    b_if.input_valid = 1'b0;
    chk("msb.ov", 64'(b_if.output_valid), 64'd1);
    chk("msb.l0", 64'(b_if.data_out), 64'h11);
    b_if.output_enable = 1'b1;
    @(posedge clk);
    #1;
    chk("msb.l1", 64'(b_if.data_out), 64'h22);
    @(posedge clk);
    #1;
    chk("msb.l2", 64'(b_if.data_out), 64'h33);
    @(posedge clk);
    #1;
    chk("msb.l3", 64'(b_if.data_out), 64'h44);
    @(posedge clk);
    #1;
    b_if.output_enable = 1'b0;
    chk("msb.empty", 64'(b_if.output_valid), 64'd0);
    chk("msb.dout0", 64'(b_if.data_out), 64'd0);

    // Random traffic against the lane-queue model
    for (int n = 0; n < 400; n++) begin
      step_a(($urandom_range(0, 9) < 6), IW'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 39) == 0), "rand");
    end
    drain_a("rand.drain");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
